// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock and gates the system reset.
// Define PLL_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise loss_cnt is tied to 0.
//
// state      | meaning
// RESET_PLL  | PLL held in reset for PLL_RST_CYCLES
// WAIT_LOCK  | PLL released, lock expected within LOCK_TIMEOUT
// STABILIZE  | lock must hold STABLE_CYCLES consecutive cycles
// RUN        | system reset released, lock monitored
// FAULT      | retries exhausted, PLL parked in reset until clear_fault
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 50,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1000,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic       lock_lost,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam bit PARAM_OK = (SYNC_STAGES >= 2) && (CNT_W >= 1) && (CNT_W <= 30) &&
                            (PLL_RST_CYCLES >= 1) && (LOCK_TIMEOUT >= 1) &&
                            (STABLE_CYCLES >= 1) && (MAX_RETRIES >= 0) &&
                            (MAX_RETRIES <= 15) && (MAX_CNT <= (1 << CNT_W));

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CNT_W-1:0]       timer_q;
  logic                   retry_evt;
  logic                   loss_evt;
  logic                   retry_exhausted;

  param_check: assert property (@(posedge refclk) PARAM_OK);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s          = sync_q[SYNC_STAGES-1];
  assign retry_exhausted = (MAX_RETRIES != 0) && (retry_cnt == RETRY_MAX);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_PLL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    retry_evt = 1'b0;
    loss_evt  = 1'b0;
    case (state_q)
      RESET_PLL: if (timer_q == RST_TC) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                  state_d   = STABILIZE;
        else if (timer_q == LOCK_TC) retry_evt = 1'b1;
      end
      STABILIZE: begin
        if (!lock_s)                   retry_evt = 1'b1;
        else if (timer_q == STABLE_TC) state_d   = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = RESET_PLL;
          loss_evt = 1'b1;
        end
      end
      FAULT:   if (clear_fault) state_d = RESET_PLL;
      default: state_d = RESET_PLL;
    endcase
    if (retry_evt) state_d = retry_exhausted ? FAULT : RESET_PLL;
  end

  always_comb begin
    pll_rst = 1'b0;
    ready   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      RESET_PLL: pll_rst = 1'b1;
      RUN:       ready   = 1'b1;
      FAULT: begin
        pll_rst = 1'b1;
        fault   = 1'b1;
      end
      default: ;
    endcase
  end

  // Every state change restarts the timer, so it never needs to wrap.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      timer_q <= '0;
    else if (state_d != state_q)
      timer_q <= '0;
    else if (state_q inside {RESET_PLL, WAIT_LOCK, STABILIZE})
      timer_q <= timer_q + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      retry_cnt <= '0;
    else if (retry_evt && (state_d == RESET_PLL))
      retry_cnt <= (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 1'b1;
    else if (((state_d == RUN) && (state_q != RUN)) || loss_evt ||
             ((state_q == FAULT) && clear_fault))
      retry_cnt <= '0;
  end

  // sys_rst_n is decoded from the next state so it changes together with ready.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sys_rst_n <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      sys_rst_n <= (state_d == RUN);
      lock_lost <= loss_evt;
    end
  end

`ifdef PLL_LOSS_CNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      loss_cnt <= '0;
    else if (loss_evt && (loss_cnt != 8'hFF))
      loss_cnt <= loss_cnt + 1'b1;
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table with a scoreboard queue, plus hand sequences
// for async reset mid-qualification and the retry-forever build.
module tb_pll_lock_supervisor;

`ifdef PLL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic       rst_n, pll_locked, clear_fault;
  logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  logic       rst_n_b, pll_locked_b, clear_fault_b;
  logic       pll_rst_b, sys_rst_n_b, ready_b, fault_b, lock_lost_b;
  logic [3:0] retry_cnt_b;
  logic [7:0] loss_cnt_b;

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .MAX_RETRIES(3), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lock_lost(lock_lost), .loss_cnt(loss_cnt)
  );

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .MAX_RETRIES(0), .CNT_W(8)
  ) dut_forever (
    .refclk(refclk), .rst_n(rst_n_b), .pll_locked(pll_locked_b), .clear_fault(clear_fault_b),
    .pll_rst(pll_rst_b), .sys_rst_n(sys_rst_n_b), .ready(ready_b), .fault(fault_b),
    .retry_cnt(retry_cnt_b), .lock_lost(lock_lost_b), .loss_cnt(loss_cnt_b)
  );

  typedef struct {
    string name;
    bit    rst_n;
    bit    locked;
    bit    clr;
    int    ncyc;
    bit    pll_rst;
    bit    sys_rst_n;
    bit    ready;
    bit    fault;
    int    retry;
    bit    lock_lost;
    int    loss;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic void add(string name, bit r, bit lk, bit c, int n, bit prst, bit srst,
                              bit rdy, bit flt, int rty, bit ll, int loss);
    vec_t v;
    v.name = name; v.rst_n = r; v.locked = lk; v.clr = c; v.ncyc = n;
    v.pll_rst = prst; v.sys_rst_n = srst; v.ready = rdy; v.fault = flt;
    v.retry = rty; v.lock_lost = ll; v.loss = loss;
    vecs.push_back(v);
  endfunction

  function automatic logic [16:0] pack(bit prst, bit srst, bit rdy, bit flt, int rty,
                                       bit ll, int loss);
    logic [3:0] r4;
    logic [7:0] l8;
    r4 = 4'(rty);
    l8 = LOSS_EN ? 8'(loss) : 8'd0;
    return {prst, srst, rdy, flt, r4, ll, l8};
  endfunction

  function automatic logic [16:0] dut_outs();
    return {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_lost, loss_cnt};
  endfunction

  task automatic check_vec(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b (pll_rst,sys_rst_n,ready,fault,retry[4],lock_lost,loss[8])",
                  name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   hi, rises, seen_fault;
    logic prev;

    rst_n = 1'b0; pll_locked = 1'b0; clear_fault = 1'b0;
    rst_n_b = 1'b0; pll_locked_b = 1'b0; clear_fault_b = 1'b0;
    repeat (3) tick();

    //   name              rst lk clr  n  prst srst rdy flt rty ll loss
    add("reset_state",      0, 0, 0,  0,  1,   0,  0,  0,  0,  0, 0);
    add("rst_hold_3",       1, 0, 0,  3,  1,   0,  0,  0,  0,  0, 0);
    add("rst_release_4",    1, 0, 0,  1,  0,   0,  0,  0,  0,  0, 0);
    add("wait_edge",        1, 0, 0, 19,  0,   0,  0,  0,  0,  0, 0);
    add("timeout1",         1, 0, 0,  1,  1,   0,  0,  0,  1,  0, 0);
    add("retry1_wait",      1, 0, 0,  4,  0,   0,  0,  0,  1,  0, 0);
    add("timeout2",         1, 0, 0, 20,  1,   0,  0,  0,  2,  0, 0);
    add("timeout3",         1, 0, 0, 24,  1,   0,  0,  0,  3,  0, 0);
    add("last_wait",        1, 0, 0, 23,  0,   0,  0,  0,  3,  0, 0);
    add("fault_entry",      1, 0, 0,  1,  1,   0,  0,  1,  3,  0, 0);
    add("fault_hold",       1, 0, 0, 10,  1,   0,  0,  1,  3,  0, 0);
    add("clear_fault",      1, 0, 1,  1,  1,   0,  0,  0,  0,  0, 0);
    add("restart_rst",      1, 0, 0,  3,  1,   0,  0,  0,  0,  0, 0);
    add("restart_wait",     1, 0, 0,  1,  0,   0,  0,  0,  0,  0, 0);
    add("pre_lock",         1, 0, 0, 10,  0,   0,  0,  0,  0,  0, 0);
    add("stab_end",         1, 1, 0, 10,  0,   0,  0,  0,  0,  0, 0);
    add("run_entry",        1, 1, 0,  1,  0,   1,  1,  0,  0,  0, 0);
    add("clr_ignored",      1, 1, 1,  1,  0,   1,  1,  0,  0,  0, 0);
    add("run_hold",         1, 1, 0,  5,  0,   1,  1,  0,  0,  0, 0);
    add("loss_sync",        1, 0, 0,  2,  0,   1,  1,  0,  0,  0, 0);
    add("loss_pulse",       1, 0, 0,  1,  1,   0,  0,  0,  0,  1, 1);
    add("loss_pulse_end",   1, 0, 0,  1,  1,   0,  0,  0,  0,  0, 1);
    add("relock_stab",      1, 1, 0, 11,  0,   0,  0,  0,  0,  0, 1);
    add("relock_run",       1, 1, 0,  1,  0,   1,  1,  0,  0,  0, 1);
    add("loss2",            1, 0, 0,  3,  1,   0,  0,  0,  0,  1, 2);
    add("glitch_pre",       1, 1, 0,  9,  0,   0,  0,  0,  0,  0, 2);
    add("glitch_low",       1, 0, 0,  1,  0,   0,  0,  0,  0,  0, 2);
    add("glitch_abort",     1, 1, 0,  2,  1,   0,  0,  0,  1,  0, 2);
    add("glitch_stab",      1, 1, 0, 12,  0,   0,  0,  0,  1,  0, 2);
    add("glitch_run",       1, 1, 0,  1,  0,   1,  1,  0,  0,  0, 2);

    foreach (vecs[i]) begin
      rst_n       = vecs[i].rst_n;
      pll_locked  = vecs[i].locked;
      clear_fault = vecs[i].clr;
      sb_q.push_back(vecs[i]);
      #1;
      repeat (vecs[i].ncyc) tick();
      e = sb_q.pop_front();
      check_vec(e.name, dut_outs(),
                pack(e.pll_rst, e.sys_rst_n, e.ready, e.fault, e.retry, e.lock_lost, e.loss));
    end

    // Async reset in the middle of STABILIZE, then a clean restart.
    pll_locked = 1'b0;
    repeat (3) tick();
    check_int("loss3_pll_rst", int'(pll_rst), 1);
    pll_locked = 1'b1;
    repeat (9) tick();
    check_int("in_stabilize_pll_rst", int'(pll_rst), 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", dut_outs(), pack(1, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (3) tick();
    check_int("restart_pll_rst_high", int'(pll_rst), 1);
    tick();
    check_int("restart_pll_rst_low", int'(pll_rst), 0);
    repeat (8) tick();
    check_int("restart_ready_early", int'(ready), 0);
    tick();
    check_vec("restart_run", dut_outs(), pack(0, 1, 1, 0, 0, 0, 0));

    // Retry-forever instance: PLL never locks.
    rst_n_b = 1'b1;
    hi = 0;
    for (int k = 0; k < 100 && pll_rst_b; k++) begin
      hi++;
      tick();
    end
    check_int("forever_pll_rst_width", hi, 4);
    rises = 0;
    seen_fault = 0;
    prev = pll_rst_b;
    for (int k = 0; k < 334; k++) begin
      tick();
      if (fault_b) seen_fault = 1;
      if (pll_rst_b && !prev) rises++;
      prev = pll_rst_b;
    end
    check_int("forever_retry_14", int'(retry_cnt_b), 14);
    for (int k = 0; k < 168; k++) begin
      tick();
      if (fault_b) seen_fault = 1;
      if (pll_rst_b && !prev) rises++;
      prev = pll_rst_b;
      if (k == 23) check_int("forever_retry_15", int'(retry_cnt_b), 15);
    end
    check_int("forever_retry_sat", int'(retry_cnt_b), 15);
    check_int("forever_no_fault", seen_fault, 0);
    check_int("forever_attempts", rises, 21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Lock supervisor for the 50 MHz-referenced system PLL (200 MHz output), running in the `refclk` domain.
- Drives the PLL's active-high `rst` and consumes the PLL's `locked` output.
- Requires lock to hold for a qualification window before releasing the system reset.
- Re-resets the PLL on lock timeout or lock loss, and latches a fault after a bounded number of retries.

Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchroniser (min 2).
- PLL_RST_CYCLES, 50: `refclk` cycles `pll_rst` is held high per attempt (1 us at 50 MHz).
- LOCK_TIMEOUT, 50000: `refclk` cycles allowed for lock after `pll_rst` release (1 ms).
- STABLE_CYCLES, 1000: consecutive locked cycles required before `ready`.
- MAX_RETRIES, 3: re-reset attempts before FAULT; 0 means retry forever.
- CNT_W, 20: shared timer width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk  in  1  50 MHz reference clock; all logic is clocked here.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL `locked` output; asynchronous to `refclk`.
- clear_fault  in  1  single-cycle pulse; exits FAULT and restarts the sequence.
- pll_rst  out  1  active-high PLL reset.
- sys_rst_n  out  1  active-low reset for downstream logic; asserts asynchronously, deasserts synchronously.
- ready  out  1  high in RUN only.
- fault  out  1  high in FAULT only.
- retry_cnt  out  4  attempts made since the last successful RUN or `clear_fault`.
- lock_lost  out  1  one-cycle pulse on loss of lock in RUN.
- loss_cnt  out  8  saturating lock-loss count (see Optional Feature).

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - State = RESET_PLL, timer = 0.
  - `pll_rst` = 1, `sys_rst_n` = 0, `ready` = 0, `fault` = 0.
  - `retry_cnt` = 0, `lock_lost` = 0, `loss_cnt` = 0, synchroniser flops = 0.
- Lock synchronisation: `lock_s` = `pll_locked` after SYNC_STAGES flops. Latency from `pll_locked` to `lock_s` is SYNC_STAGES cycles.
- RESET_PLL:
  - `pll_rst` = 1; the timer counts.
  - At timer == PLL_RST_CYCLES-1: go to WAIT_LOCK, clear timer.
- WAIT_LOCK:
  - `pll_rst` = 0.
  - If `lock_s` = 1: go to STABILIZE, clear timer.
  - Else at timer == LOCK_TIMEOUT-1: retry (see retry rule).
- STABILIZE:
  - `lock_s` = 0: retry immediately.
  - `lock_s` = 1 for STABLE_CYCLES consecutive cycles: go to RUN, set `retry_cnt` = 0.
- RUN:
  - `ready` = 1; `sys_rst_n` deasserts on the registered transition into RUN.
  - `lock_s` falling: `lock_lost` pulses for one cycle, `sys_rst_n` = 0 and `ready` = 0 in the same cycle, `retry_cnt` = 0, `loss_cnt` increments, state goes to RESET_PLL.
- Retry rule:
  - If MAX_RETRIES != 0 and `retry_cnt` == MAX_RETRIES: go to FAULT.
  - Else: `retry_cnt` increments (saturating at 15), state goes to RESET_PLL, timer clears.
- FAULT:
  - `pll_rst` = 1 (PLL held in reset), `sys_rst_n` = 0, `fault` = 1.
  - Only `clear_fault` or `rst_n` exits: go to RESET_PLL, `retry_cnt` = 0, `fault` = 0.
- `sys_rst_n` is low in every state except RUN. It is registered with no combinational path from `pll_locked`.
- `clear_fault` is ignored outside FAULT.
- Lock glitch shorter than the synchroniser resolution may be missed. This is accepted; the PLL `locked` output is level-stable.
- Timer is compared for equality only and never wraps. CNT_W sizing errors are a parameter-check assertion in simulation.

Optional Feature:
- Macro PLL_LOSS_CNT_EN.
- Defined: `loss_cnt` is an 8-bit counter incremented on each `lock_lost` pulse. It saturates at 255 and is cleared only by `rst_n`.
- Undefined: `loss_cnt` is tied to 0 and no counter flops are inferred. All other behaviour is identical.

Test Plan:
- Nominal lock (PLL_RST_CYCLES=4, STABLE_CYCLES=8, SYNC_STAGES=2): `pll_locked` rises 10 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles; `ready` and `sys_rst_n` rise 2+8(+1 register) cycles after `pll_locked`; `retry_cnt` = 0.
- Timeout retries (LOCK_TIMEOUT=20, MAX_RETRIES=3): `pll_locked` held 0 -> 4 `pll_rst` pulses of 4 cycles; `retry_cnt` steps 1, 2, 3; then `fault` = 1, `pll_rst` stays 1; `clear_fault` pulse -> RESET_PLL, `retry_cnt` = 0.
- Stabilise glitch: `pll_locked` high 5 cycles, low 1, high -> STABILIZE aborts; `retry_cnt` = 1; new `pll_rst` pulse; `ready` never asserts early.
- Lock loss in RUN: drop `pll_locked` -> after 2 sync cycles, `lock_lost` pulses once; `sys_rst_n` = 0 and `ready` = 0 the same cycle; `loss_cnt` = 1 with PLL_LOSS_CNT_EN, 0 without; relock returns to RUN.
- Async reset mid-STABILIZE: `rst_n` low for 1 ns between edges -> all outputs take reset values immediately; restart from RESET_PLL.
- MAX_RETRIES=0, `pll_locked` held 0 for 20 attempts -> never FAULT; `retry_cnt` saturates at 15.
